tx_frame_packer: RTL and testbench

- Sits between tx_protocol and ft245_interface and wraps each outgoing SI byte stream into a self-delimiting frame: SOF, source id, payload, 16-bit length, XOR checksum.
- Lets the host resynchronise after dropped bytes and split channel dumps without tracking byte counts.
- Consumes an 8-bit SI stream with eof; produces an 8-bit SI stream with no eof, which feeds the ft245_interface tx side.

---
 rtl/tx_frame_packer_pkg.sv | 24 ++
 rtl/tx_frame_packer.sv | 181 ++++++++++++++++++
 tb/tb_tx_frame_packer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_packer_pkg.sv
// Shared constants and state encoding for the tx frame packer.
// The host decoder depends on the same SOF value, length width and
// maximum payload, so they are kept here in one place.
package tx_frame_packer_pkg;

  localparam int          FRAME_DATA_WIDTH  = 8;
  localparam int          FRAME_LEN_WIDTH   = 16;
  localparam int          FRAME_MAX_PAYLOAD = 4096;
  localparam logic [7:0]  FRAME_SOF         = 8'hA5;

  // The state names the next byte to place in the output slot. IDLE both
  // waits for a stream and emits the SOF byte, so the SOF encoding is
  // reserved and treated as illegal by the packer.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF     = 3'd1,
    ST_SRC     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_LEN_H   = 3'd4,
    ST_LEN_L   = 3'd5,
    ST_CHK     = 3'd6
  } state_e;

endpackage

// File: rtl/tx_frame_packer.sv
// tx_frame_packer: wraps an SI byte stream (with eof) into frames of
//   SOF, src, payload..., len_h, len_l, chk   (chk = XOR of all but SOF)
// Payloads longer than MAX_PAYLOAD are split into several frames.
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   src_id            source tag, sampled when a frame opens
//   in_data/in_rdy/in_eof/in_ack   upstream SI stream; in_ack is a
//                     one-cycle registered pulse per consumed byte
//   out_data/out_rdy/out_ack       downstream SI stream; out_data is held
//                     until out_ack while out_rdy is high
//   busy              high from frame open until the checksum is acked
module tx_frame_packer
  import tx_frame_packer_pkg::*;
#(
  parameter int                    DATA_WIDTH  = FRAME_DATA_WIDTH,
  parameter int                    LEN_WIDTH   = FRAME_LEN_WIDTH,
  parameter int                    MAX_PAYLOAD = FRAME_MAX_PAYLOAD,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE    = FRAME_SOF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            src_id,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_rdy,
  input  logic                  in_eof,
  output logic                  in_ack,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_rdy,
  input  logic                  out_ack,
  output logic                  busy
);

  state_e                  state_r, state_s;
  logic [DATA_WIDTH-1:0]   out_data_r, out_data_s;
  logic                    out_rdy_r, out_rdy_s;
  logic                    in_ack_r, in_ack_s;
  logic                    busy_r, busy_s;
  logic [LEN_WIDTH-1:0]    count_r, count_s;
  logic [DATA_WIDTH-1:0]   chk_r, chk_s;
  logic [7:0]              src_r, src_s;
  logic                    chk_sent_r, chk_sent_s;
  logic                    slot_free_s;
  logic [LEN_WIDTH-1:0]    count_inc_s;
  logic [DATA_WIDTH-1:0]   len_h_s, len_l_s;

  assign slot_free_s = !out_rdy_r || out_ack;
  assign count_inc_s = count_r + LEN_WIDTH'(1);
  assign len_h_s     = count_r[LEN_WIDTH-1 -: DATA_WIDTH];
  assign len_l_s     = count_r[DATA_WIDTH-1:0];

  // Next-state, output slot, counter and checksum logic.
  always_comb begin
    state_s    = state_r;
    out_data_s = out_data_r;
    // A free slot with nothing new to load empties on this edge.
    out_rdy_s  = out_rdy_r && !out_ack;
    in_ack_s   = 1'b0;
    busy_s     = busy_r;
    count_s    = count_r;
    chk_s      = chk_r;
    src_s      = src_r;
    chk_sent_s = chk_sent_r;

    case (state_r)
      ST_IDLE: begin
        if (in_rdy && slot_free_s) begin
          src_s      = src_id;
          out_data_s = SOF_BYTE;
          out_rdy_s  = 1'b1;
          busy_s     = 1'b1;
          chk_s      = '0;
          count_s    = '0;
          chk_sent_s = 1'b0;
          state_s    = ST_SRC;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_SRC: begin
        if (slot_free_s) begin
          out_data_s = DATA_WIDTH'(src_r);
          out_rdy_s  = 1'b1;
          chk_s      = chk_r ^ DATA_WIDTH'(src_r);
          state_s    = ST_PAYLOAD;
        end else begin
          state_s    = ST_SRC;
        end
      end
      ST_PAYLOAD: begin
        // in_rdy is ignored while in_ack is high: the source has not yet
        // had a chance to advance to the next byte.
        if (slot_free_s && in_rdy && !in_ack_r) begin
          out_data_s = in_data;
          out_rdy_s  = 1'b1;
          in_ack_s   = 1'b1;
          count_s    = count_inc_s;
          chk_s      = chk_r ^ in_data;
          if (in_eof || (count_inc_s == LEN_WIDTH'(MAX_PAYLOAD))) begin
            state_s  = ST_LEN_H;
          end else begin
            state_s  = ST_PAYLOAD;
          end
        end else begin
          state_s    = ST_PAYLOAD;
        end
      end
      ST_LEN_H: begin
        if (slot_free_s) begin
          out_data_s = len_h_s;
          out_rdy_s  = 1'b1;
          chk_s      = chk_r ^ len_h_s;
          state_s    = ST_LEN_L;
        end else begin
          state_s    = ST_LEN_H;
        end
      end
      ST_LEN_L: begin
        if (slot_free_s) begin
          out_data_s = len_l_s;
          out_rdy_s  = 1'b1;
          chk_s      = chk_r ^ len_l_s;
          state_s    = ST_CHK;
        end else begin
          state_s    = ST_LEN_L;
        end
      end
      ST_CHK: begin
        // First load the checksum, then wait for its acknowledge.
        if (!chk_sent_r && slot_free_s) begin
          out_data_s = chk_r;
          out_rdy_s  = 1'b1;
          chk_sent_s = 1'b1;
          state_s    = ST_CHK;
        end else if (chk_sent_r && out_ack) begin
          busy_s     = 1'b0;
          chk_sent_s = 1'b0;
          state_s    = ST_IDLE;
        end else begin
          state_s    = ST_CHK;
        end
      end
      default: begin
        out_rdy_s  = 1'b0;
        busy_s     = 1'b0;
        chk_sent_s = 1'b0;
        state_s    = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      out_data_r <= '0;
      out_rdy_r  <= 1'b0;
      in_ack_r   <= 1'b0;
      busy_r     <= 1'b0;
      count_r    <= '0;
      chk_r      <= '0;
      src_r      <= 8'h00;
      chk_sent_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      out_data_r <= out_data_s;
      out_rdy_r  <= out_rdy_s;
      in_ack_r   <= in_ack_s;
      busy_r     <= busy_s;
      count_r    <= count_s;
      chk_r      <= chk_s;
      src_r      <= src_s;
      chk_sent_r <= chk_sent_s;
    end
  end

  assign out_data = out_data_r;
  assign out_rdy  = out_rdy_r;
  assign in_ack   = in_ack_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_tx_frame_packer.sv
// Scoreboard bench for tx_frame_packer. Two instances: index 0 uses the
// default maximum payload, index 1 closes segments after 4 bytes.
module tb_tx_frame_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src_id   [2];
  logic [7:0] in_data  [2];
  logic [7:0] out_data [2];
  logic [1:0] in_rdy, in_eof, in_ack, out_rdy, out_ack, busy;

  int checks   = 0;
  int failures = 0;
  int ack_mode = 0;
  bit mon_en   = 1'b0;
  int ack_cnt  [2];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  always #5 clk = ~clk;

  tx_frame_packer u_dut0 (
    .clk(clk), .rst(rst), .src_id(src_id[0]),
    .in_data(in_data[0]), .in_rdy(in_rdy[0]), .in_eof(in_eof[0]), .in_ack(in_ack[0]),
    .out_data(out_data[0]), .out_rdy(out_rdy[0]), .out_ack(out_ack[0]), .busy(busy[0])
  );

  tx_frame_packer #(.MAX_PAYLOAD(4)) u_dut1 (
    .clk(clk), .rst(rst), .src_id(src_id[1]),
    .in_data(in_data[1]), .in_rdy(in_rdy[1]), .in_eof(in_eof[1]), .in_ack(in_ack[1]),
    .out_data(out_data[1]), .out_rdy(out_rdy[1]), .out_ack(out_ack[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push_exp(input int d, input logic [7:0] b);
    if (d == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
  endtask

  // Reference model: split the stream into segments and append the framed
  // bytes of each segment to the expected queue.
  task automatic model_stream(input int d, input logic [7:0] src, input logic [7:0] bytes[$]);
    int maxp;
    int pos;
    int n;
    logic [7:0]  chk;
    logic [15:0] len;
    maxp = (d == 0) ? 4096 : 4;
    pos  = 0;
    while (pos < bytes.size()) begin
      n = bytes.size() - pos;
      if (n > maxp) n = maxp;
      chk = src;
      push_exp(d, 8'hA5);
      push_exp(d, src);
      for (int i = 0; i < n; i++) begin
        push_exp(d, bytes[pos + i]);
        chk = chk ^ bytes[pos + i];
      end
      len = 16'(n);
      push_exp(d, len[15:8]);
      push_exp(d, len[7:0]);
      chk = chk ^ len[15:8] ^ len[7:0];
      push_exp(d, chk);
      pos += n;
    end
  endtask

  // Sink: drives out_ack according to ack_mode (0 always, 1 random,
  // 2 withhold about five cycles per byte).
  initial begin
    int hold [2];
    out_ack = 2'b00;
    hold[0] = 0;
    hold[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        case (ack_mode)
          0: out_ack[d] = 1'b1;
          1: out_ack[d] = ($urandom_range(0, 2) != 0);
          default: begin
            if (out_rdy[d]) begin
              if (hold[d] >= 5) begin
                out_ack[d] = 1'b1;
                hold[d]    = 0;
              end else begin
                out_ack[d] = 1'b0;
                hold[d]++;
              end
            end else begin
              out_ack[d] = 1'b0;
              hold[d]    = 0;
            end
          end
        endcase
      end
    end
  end

  // Monitor: scoreboard pop on each accepted byte, plus handshake rules.
  logic [1:0] prev_rdy, prev_ack, prev_inack;
  logic [7:0] prev_data [2];
  logic [7:0] prev_in   [2];
  initial begin
    prev_rdy = 2'b00; prev_ack = 2'b00; prev_inack = 2'b00;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
  end
  always @(negedge clk) begin
    logic [7:0] e;
    for (int d = 0; d < 2; d++) begin
      if (rst === 1'b1 && in_ack[d] === 1'b1) ack_cnt[d]++;
      if (rst !== 1'b1 || !mon_en) begin
        prev_rdy[d] = 1'b0; prev_ack[d] = 1'b0; prev_inack[d] = 1'b0;
      end else begin
        if (prev_rdy[d] && !prev_ack[d] && out_rdy[d])
          check($sformatf("stable_d%0d", d), {24'h0, out_data[d]}, {24'h0, prev_data[d]});
        if (in_ack[d]) begin
          check($sformatf("inack_slot_free_d%0d", d), {31'h0, !prev_rdy[d] || prev_ack[d]}, 32'h1);
          check($sformatf("inack_single_d%0d", d), {31'h0, prev_inack[d]}, 32'h0);
          check($sformatf("inack_data_d%0d", d), {23'h0, out_rdy[d], out_data[d]}, {23'h1, prev_in[d]});
        end
        if (out_rdy[d] && out_ack[d]) begin
          if (qsize(d) == 0) begin
            check($sformatf("unexpected_byte_d%0d", d), {24'h0, out_data[d]}, 32'hFFFF_FFFF);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("out_byte_d%0d", d), {24'h0, out_data[d]}, {24'h0, e});
          end
        end
        prev_rdy[d]   = out_rdy[d];
        prev_ack[d]   = out_ack[d];
        prev_inack[d] = in_ack[d];
        prev_data[d]  = out_data[d];
      end
      prev_in[d] = in_data[d];
    end
  end

  // Source: presents each byte with in_rdy high until in_ack is seen.
  task automatic run_stream(input int d, input logic [7:0] src, input logic [7:0] bytes[$],
                            input bit scramble, input bit gaps);
    int  w;
    int  start_acks;
    bit  idle_start;
    model_stream(d, src, bytes);
    start_acks = ack_cnt[d];
    src_id[d]  = src;
    idle_start = !busy[d] && !out_rdy[d];
    for (int i = 0; i < bytes.size(); i++) begin
      in_data[d] = bytes[i];
      in_eof[d]  = (i == bytes.size() - 1);
      in_rdy[d]  = 1'b1;
      w = 0;
      if (i == 0 && idle_start) begin
        @(posedge clk); #1; w++;
        check($sformatf("sof_latency_d%0d", d), {23'h0, out_rdy[d], out_data[d]}, {23'h1, 8'hA5});
      end
      if (!in_ack[d] || i > 0 || w == 0) begin
        do begin
          @(posedge clk); #1; w++;
        end while (!in_ack[d] && w < 400);
      end
      check($sformatf("inack_timeout_d%0d", d), {31'h0, in_ack[d]}, 32'h1);
      if (!in_ack[d]) break;
      if (scramble && i == 0) src_id[d] = 8'($urandom);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_rdy[d] = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
    end
    in_rdy[d] = 1'b0;
    in_eof[d] = 1'b0;
    w = 0;
    while (qsize(d) != 0 && w < 4000) begin
      @(posedge clk); #1; w++;
    end
    check($sformatf("drain_timeout_d%0d", d), {31'h0, qsize(d) == 0}, 32'h1);
    @(posedge clk); #1;
    check($sformatf("busy_idle_d%0d", d), {30'h0, busy[d], out_rdy[d]}, 32'h0);
    check($sformatf("inack_count_d%0d", d), 32'(ack_cnt[d] - start_acks), 32'(bytes.size()));
    if (d == 0) exp_q0.delete(); else exp_q1.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int n;
    int w;
    for (int d = 0; d < 2; d++) begin
      src_id[d] = 8'h00; in_data[d] = 8'h00;
    end
    in_rdy = 2'b00; in_eof = 2'b00;
    rst = 1'b1;
    #2 rst = 1'b0;
    #20;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_out_d%0d", d), {21'h0, out_rdy[d], in_ack[d], busy[d], out_data[d]}, 32'h0);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;

    // Basic frame, immediate acks.
    ack_mode = 0;
    q = '{8'h10, 8'h20, 8'h30};
    run_stream(0, 8'h01, q, 1'b0, 1'b0);
    q = '{8'hFF};
    run_stream(0, 8'h02, q, 1'b0, 1'b0);
    // Forced segment close at 4 bytes.
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_stream(1, 8'h00, q, 1'b0, 1'b0);
    // Slow sink.
    ack_mode = 2;
    q = '{8'h10, 8'h20, 8'h30};
    run_stream(0, 8'h01, q, 1'b0, 1'b0);

    // Reset in the middle of a frame, after the second payload byte.
    ack_mode = 0;
    mon_en = 1'b0;
    src_id[0] = 8'h01; in_data[0] = 8'h10; in_eof[0] = 1'b0; in_rdy[0] = 1'b1;
    n = 0; w = 0;
    while (n < 2 && w < 100) begin
      @(posedge clk); #1; w++;
      if (in_ack[0]) begin
        n++;
        in_data[0] = 8'h20;
      end
    end
    check("rst_wait", 32'(n), 32'd2);
    rst = 1'b0;
    #1;
    check("rst_mid_frame", {29'h0, out_rdy[0], in_ack[0], busy[0]}, 32'h0);
    in_rdy[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;
    q = '{8'hAA};
    run_stream(0, 8'h03, q, 1'b0, 1'b0);

    // Long payload so the high length byte is non-zero.
    q = {};
    for (int i = 0; i < 300; i++) q.push_back(8'($urandom));
    run_stream(0, 8'($urandom), q, 1'b0, 1'b0);

    // Randomised streams, random acks and source gaps.
    ack_mode = 1;
    for (int k = 0; k < 12; k++) begin
      q = {};
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_stream(0, 8'($urandom), q, 1'b1, 1'b1);
    end
    for (int k = 0; k < 10; k++) begin
      q = {};
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_stream(1, 8'($urandom), q, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
